// File: rtl/mp3_frame_rx_pkg.sv
// rtl/mp3_frame_rx_pkg.sv - shared constants, state types and checksum helper for the MP3 reply receiver
package mp3_frame_rx_pkg;

  localparam logic [7:0] MP3_SOF = 8'h7E;
  localparam logic [7:0] MP3_VER = 8'hFF;
  localparam logic [7:0] MP3_LEN = 8'h06;
  localparam logic [7:0] MP3_EOF = 8'hEF;

  localparam logic [7:0] MP3_CMD_TRACK_DONE = 8'h3D;
  localparam logic [7:0] MP3_CMD_INIT       = 8'h3F;
  localparam logic [7:0] MP3_CMD_ERROR      = 8'h40;
  localparam logic [7:0] MP3_CMD_VOLUME     = 8'h43;

  localparam int MP3_CLKS_PER_BIT = 5208;
  localparam int MP3_TIMEOUT_CLKS = 1_000_000;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  typedef enum logic [3:0] {
    F_WAIT_SOF,
    F_VER,
    F_LEN,
    F_CMD,
    F_FB,
    F_P1,
    F_P2,
    F_CKH,
    F_CKL,
    F_EOF
  } frame_state_t;

  // Two's complement of the running byte sum is what the module sends as {CKH,CKL}.
  function automatic logic [15:0] mp3_checksum(input logic [15:0] sum);
    return (~sum) + 16'd1;
  endfunction

endpackage

// File: rtl/mp3_frame_rx_uart.sv
// rtl/mp3_frame_rx_uart.sv - 8N1 byte receiver with input synchronizer and mid-bit sampling
module uart_rx_byte
  import mp3_frame_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = MP3_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       byte_valid,
  output logic       byte_err
);

  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

  logic            rx_meta, rx_sync, rx_prev;
  rx_state_t       state, state_d;
  logic [CW-1:0]   cnt;
  logic [2:0]      bit_idx;
  logic [7:0]      shreg;

  assign data = shreg;

  always_comb begin
    state_d = state;
    case (state)
      RX_IDLE:  if (rx_prev && !rx_sync) state_d = RX_START;
      RX_START: if (cnt == HALF_M1) state_d = rx_sync ? RX_IDLE : RX_DATA;
      RX_DATA:  if (cnt == FULL_M1 && bit_idx == 3'd7) state_d = RX_STOP;
      RX_STOP:  if (cnt == FULL_M1) state_d = RX_IDLE;
      default:  state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta    <= 1'b1;
      rx_sync    <= 1'b1;
      rx_prev    <= 1'b1;
      state      <= RX_IDLE;
      cnt        <= '0;
      bit_idx    <= 3'd0;
      shreg      <= 8'h00;
      byte_valid <= 1'b0;
      byte_err   <= 1'b0;
    end else begin
      rx_meta    <= rx;
      rx_sync    <= rx_meta;
      rx_prev    <= rx_sync;
      state      <= state_d;
      byte_valid <= 1'b0;
      byte_err   <= 1'b0;

      // Counter restarts on every state change and at each data mid-bit.
      if (state != state_d || (state == RX_DATA && cnt == FULL_M1))
        cnt <= '0;
      else if (state != RX_IDLE)
        cnt <= cnt + 1'b1;

      if (state == RX_DATA && cnt == FULL_M1) begin
        shreg   <= {rx_sync, shreg[7:1]};
        bit_idx <= bit_idx + 3'd1;
      end

      if (state == RX_STOP && cnt == FULL_M1) begin
        if (rx_sync) byte_valid <= 1'b1;
        else         byte_err   <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/mp3_frame_rx.sv
// rtl/mp3_frame_rx.sv - MP3-TF-16P reply frame decoder: framing, checksum, timeout, result registers
module mp3_frame_rx
  import mp3_frame_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = MP3_CLKS_PER_BIT,
  parameter int TIMEOUT_CLKS = MP3_TIMEOUT_CLKS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx,
  output logic        frame_valid,
  output logic [7:0]  cmd,
  output logic        feedback,
  output logic [15:0] param,
  output logic        chk_err,
  output logic        frame_err,
  output logic        busy
);

  logic [7:0]   rx_byte;
  logic         byte_valid, byte_err;
  frame_state_t state, state_d;
  logic         fv_d, ce_d, fe_d;
  logic [15:0]  sum;
  logic [7:0]   cmd_t, fb_t, p1_t, p2_t, ckh_t, ckl_t;
  logic [31:0]  to_cnt;
  logic         chk_ok, to_hit;

  uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .data       (rx_byte),
    .byte_valid (byte_valid),
    .byte_err   (byte_err)
  );

  assign busy   = (state != F_WAIT_SOF);
  assign chk_ok = ({ckh_t, ckl_t} == mp3_checksum(sum));
  assign to_hit = busy && (to_cnt == 32'(TIMEOUT_CLKS - 1));

  always_comb begin
    state_d = state;
    fv_d    = 1'b0;
    ce_d    = 1'b0;
    fe_d    = 1'b0;
    if (byte_err) begin
      if (busy) begin
        fe_d    = 1'b1;
        state_d = F_WAIT_SOF;
      end
    end else if (byte_valid) begin
      case (state)
        F_WAIT_SOF: if (rx_byte == MP3_SOF) state_d = F_VER;
        F_VER:      state_d = (rx_byte == MP3_VER) ? F_LEN : F_WAIT_SOF;
        F_LEN:      state_d = (rx_byte == MP3_LEN) ? F_CMD : F_WAIT_SOF;
        F_CMD:      state_d = F_FB;
        F_FB:       state_d = F_P1;
        F_P1:       state_d = F_P2;
        F_P2:       state_d = F_CKH;
        F_CKH:      state_d = F_CKL;
        F_CKL:      state_d = F_EOF;
        F_EOF: begin
          state_d = F_WAIT_SOF;
          if (rx_byte == MP3_EOF) begin
            fv_d = chk_ok;
            ce_d = !chk_ok;
          end
        end
        default:    state_d = F_WAIT_SOF;
      endcase
      // A bad fixed byte is an error; if it was itself a SOF, treat it as a new frame start.
      if ((state == F_VER && rx_byte != MP3_VER) || (state == F_LEN && rx_byte != MP3_LEN) ||
          (state == F_EOF && rx_byte != MP3_EOF)) begin
        fe_d    = 1'b1;
        state_d = (rx_byte == MP3_SOF) ? F_VER : F_WAIT_SOF;
      end
    end else if (to_hit) begin
      fe_d    = 1'b1;
      state_d = F_WAIT_SOF;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= F_WAIT_SOF;
      frame_valid <= 1'b0;
      chk_err     <= 1'b0;
      frame_err   <= 1'b0;
      cmd         <= 8'h00;
      feedback    <= 1'b0;
      param       <= 16'h0000;
      sum         <= 16'h0000;
      cmd_t       <= 8'h00;
      fb_t        <= 8'h00;
      p1_t        <= 8'h00;
      p2_t        <= 8'h00;
      ckh_t       <= 8'h00;
      ckl_t       <= 8'h00;
      to_cnt      <= 32'd0;
    end else begin
      state       <= state_d;
      frame_valid <= fv_d;
      chk_err     <= ce_d;
      frame_err   <= fe_d;

      if (!busy || byte_valid || state_d == F_WAIT_SOF) to_cnt <= 32'd0;
      else                                              to_cnt <= to_cnt + 32'd1;

      if (byte_valid) begin
        if (state_d == F_VER) begin
          sum <= 16'h0000;
        end else begin
          case (state)
            F_VER, F_LEN: sum <= sum + {8'h00, rx_byte};
            F_CMD: begin cmd_t <= rx_byte; sum <= sum + {8'h00, rx_byte}; end
            F_FB:  begin fb_t  <= rx_byte; sum <= sum + {8'h00, rx_byte}; end
            F_P1:  begin p1_t  <= rx_byte; sum <= sum + {8'h00, rx_byte}; end
            F_P2:  begin p2_t  <= rx_byte; sum <= sum + {8'h00, rx_byte}; end
            F_CKH: ckh_t <= rx_byte;
            F_CKL: ckl_t <= rx_byte;
            default: ;
          endcase
        end
      end

      if (fv_d) begin
        cmd      <= cmd_t;
        feedback <= fb_t[0];
        param    <= {p1_t, p2_t};
      end
    end
  end

endmodule
